tristate_bus_arbiter: RTL

Round-robin arbiter that shares one tristate bus among `N_REQ` requesters whose drivers are `bufif1` primitives. It issues a one-hot grant, drives the matching buffer enable, and inserts a turnaround gap with every enable low whenever ownership changes (break-before-make), so two drivers never fight on the wire. It sits between the requesting blocks and the bufif driver bank, replacing a fixed `sel` line with a sequenced one.

---
 rtl/tristate_bus_arbiter_if.sv | 16 +
 rtl/tristate_bus_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter_if.sv
// Bus-side signal bundle for tristate_bus_arbiter: requests in, grant and bufif enables out.
// master = arbiter side, slave = requester / driver-bank side.
interface tristate_bus_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   localparam int unsigned SW = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] drv_en;
   logic [SW-1:0]    sel;
   logic             bus_idle;

   modport master (input req, output grant, output drv_en, output sel, output bus_idle);
   modport slave  (output req, input grant, input drv_en, input sel, input bus_idle);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin, break-before-make arbiter for a bank of bufif1 bus drivers.
// Optional owner preemption after HOLD_MAX cycles: define ARB_HOLD_LIMIT_EN.
module tristate_bus_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned TURN     = 1,
   parameter int unsigned HOLD_MAX = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   tristate_bus_arbiter_if.master bus
);
   localparam int unsigned SW = $clog2(N_REQ);
   localparam int unsigned GW = 3;
   localparam int unsigned HW = 8;

   if (N_REQ < 2 || N_REQ > 16 || TURN < 1 || TURN > 7 || HOLD_MAX < 2 || HOLD_MAX > 255)
   begin : g_param_check
      $error("tristate_bus_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   state_t           state, state_n;
   logic [SW-1:0]    ptr, ptr_n;
   logic [SW-1:0]    sel_q, sel_n;
   logic [SW-1:0]    win, idx;
   logic             win_vld;
   logic [N_REQ-1:0] win_oh;
   logic [N_REQ-1:0] grant_q, grant_n;
   logic [N_REQ-1:0] drv_q, drv_n;
   logic             idle_q, idle_n;
   logic [GW-1:0]    gap_cnt, gap_n;
`ifdef ARB_HOLD_LIMIT_EN
   logic [HW-1:0]    hold_cnt, hold_n;
   logic             preempt;
`endif

   // Round-robin search starting at ptr; first requester found wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = SW'((32'(ptr) + i) % N_REQ);
         if (!win_vld && bus.req[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   assign win_oh = N_REQ'(1) << win;

   // Next state and next registered outputs.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      sel_n   = sel_q;
      grant_n = grant_q;
      drv_n   = drv_q;
      idle_n  = idle_q;
      gap_n   = gap_cnt;
`ifdef ARB_HOLD_LIMIT_EN
      hold_n  = hold_cnt;
      preempt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_n = OWN;
               grant_n = win_oh;
               drv_n   = win_oh;
               sel_n   = win;
               ptr_n   = SW'((32'(win) + 32'd1) % N_REQ);
               idle_n  = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
               hold_n  = '0;
`endif
            end
         end
         OWN: begin
`ifdef ARB_HOLD_LIMIT_EN
            hold_n  = (hold_cnt == HW'(HOLD_MAX - 1)) ? hold_cnt : hold_cnt + HW'(1);
            preempt = (hold_cnt == HW'(HOLD_MAX - 1)) && (|(bus.req & ~grant_q));
            if (!bus.req[sel_q] || preempt) begin
`else
            if (!bus.req[sel_q]) begin
`endif
               state_n = GAP;
               grant_n = '0;
               drv_n   = '0;
               gap_n   = '0;
            end
         end
         GAP: begin
            if (gap_cnt == GW'(TURN - 1)) begin
               if (win_vld) begin
                  state_n = OWN;
                  grant_n = win_oh;
                  drv_n   = win_oh;
                  sel_n   = win;
                  ptr_n   = SW'((32'(win) + 32'd1) % N_REQ);
`ifdef ARB_HOLD_LIMIT_EN
                  hold_n  = '0;
`endif
               end else begin
                  state_n = IDLE;
                  idle_n  = 1'b1;
               end
            end else begin
               gap_n = gap_cnt + GW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            drv_n   = '0;
            idle_n  = 1'b1;
         end
      endcase
   end

   // State and output registers; reset drops every enable on the first low edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         sel_q   <= '0;
         grant_q <= '0;
         drv_q   <= '0;
         idle_q  <= 1'b1;
         gap_cnt <= '0;
`ifdef ARB_HOLD_LIMIT_EN
         hold_cnt <= '0;
`endif
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         sel_q   <= sel_n;
         grant_q <= grant_n;
         drv_q   <= drv_n;
         idle_q  <= idle_n;
         gap_cnt <= gap_n;
`ifdef ARB_HOLD_LIMIT_EN
         hold_cnt <= hold_n;
`endif
      end
   end

   assign bus.grant    = grant_q;
   assign bus.drv_en   = drv_q;
   assign bus.sel      = sel_q;
   assign bus.bus_idle = idle_q;
endmodule
